// File: rtl/pulse_pattern_writer.sv
// pulse_pattern_writer: fills a pattern word one serial bit at a time at a rotating one-hot select position
module pulse_pattern_writer #(
   parameter int WIDTH = 32,
   parameter int LEN_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic [WIDTH-1:0] select,
   output logic [WIDTH-1:0] pulse,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] count
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] eff_len;
   logic [LEN_W-1:0] count_nxt;
   logic             xfer;
   assign eff_len   = (len == '0 || len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
   assign count_nxt = count + 1'b1;
   assign xfer      = bit_valid && bit_ready;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         len_q     <= '0;
         pulse     <= '0;
         select    <= '0;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state     <= LOAD;
               len_q     <= eff_len;
               pulse     <= '0;
               select    <= WIDTH'(1);
               count     <= '0;
               busy      <= 1'b1;
               bit_ready <= 1'b1;
            end
            LOAD: if (xfer) begin
               pulse <= bit_in ? (pulse | select) : (pulse & ~select);
               count <= count_nxt;
               if (count_nxt == len_q) begin
                  state     <= DONE;
                  select    <= '0;
                  busy      <= 1'b0;
                  bit_ready <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  select <= {select[WIDTH-2:0], select[WIDTH-1]};
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               select    <= '0;
               busy      <= 1'b0;
               done      <= 1'b0;
               bit_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/pulse_pattern_writer.md
# pulse_pattern_writer

Sequential writer that builds the 32-bit `pulse` pattern word consumed by the one-hot `select` bit-lookup logic. It accepts a serial bit stream over a valid/ready handshake and writes each bit into the position addressed by a rotating one-hot `select` pointer. It publishes the finished pattern with a one-cycle `done` strobe. It sits upstream of the lookup: the writer fills the word, and the lookup reads single bits back out of it.

## Interface
- `WIDTH`, 32, pattern word width; `select` and `pulse` share this width.
- `LEN_W`, 6, width of `len`; must satisfy 2^`LEN_W` > `WIDTH`.

- `clk`  in  1  single rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a new pattern load; sampled only in IDLE.
- `len`  in  `LEN_W`  number of bits to write, sampled with `start`. 0 or any value > `WIDTH` means `WIDTH`.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is valid.
- `bit_ready`  out  1  writer accepts a bit this cycle.
- `select`  out  `WIDTH`  one-hot position of the next write; all-zero when not loading.
- `pulse`  out  `WIDTH`  pattern word under construction / completed.
- `busy`  out  1  high in LOAD.
- `done`  out  1  one-cycle strobe when the pattern is complete.
- `count`  out  `LEN_W`  bits written in the current/last load.

## Operation
- States: IDLE, LOAD, DONE.
- Reset (`rst_n`=0 at a clock edge), from any state including mid-load:
  - state goes to IDLE.
  - `pulse`=0, `select`=0, `count`=0, `busy`=0, `done`=0, `bit_ready`=0.
- IDLE, `start`=1:
  - Latch the effective length L (1..`WIDTH`).
  - Clear `pulse` to 0, set `select`=1 (bit 0), set `count`=0.
  - Go to LOAD.
- IDLE, `start`=0: all registers hold; `pulse` keeps the last completed pattern.
- LOAD:
  - `bit_ready`=1, decoded from state only; no combinational path from `bit_valid`.
  - Transfer occurs when `bit_valid` && `bit_ready`.
  - On a transfer: for every i with `select`[i]=1, set `pulse`[i] <= `bit_in`. Then rotate `select` left by one and increment `count`.
  - When the transfer makes `count` = L: go to DONE and set `select`=0.
  - `start` is ignored in LOAD.
- DONE (one cycle):
  - `done`=1, `bit_ready`=0, `pulse` stable.
  - Go to IDLE unconditionally; `start` is ignored in DONE.
- Bits above L-1 stay 0 for a short load.
- `select` rotates from bit `WIDTH`-1 to bit 0, but only at the transition into DONE, where it is forced to 0. `select` is therefore never non-zero outside LOAD.
- `count` saturates at L; no wrap inside a load.
- `busy` = (state==LOAD).
- All outputs are registered or decoded from state; no combinational input-to-output paths.

## Timing
- `start` at edge N puts the block in LOAD, so `bit_ready`=1 from cycle N+1.
- One bit per cycle at full throughput. A back-to-back `WIDTH`-bit load takes `WIDTH` LOAD cycles.
- `done` is asserted in the cycle after the final transfer. The final `pulse` value is visible in that same cycle.
- The earliest next `start` is accepted in the cycle after DONE, i.e. IDLE. Minimum `start`-to-`start` spacing is L+2 cycles.
- `bit_valid` gaps stall the load with no timeout; `select` and `count` hold during the stall.

## Test plan
- Reset then full load:
  - Stimulus: `start`, `len`=0, then stream bit k = (k==1 || k==3) for 32 consecutive cycles.
  - Required: `pulse`=32'h0000000A. `done` high exactly 1 cycle, 33 cycles after `start` is sampled. `select`=0 afterward. `count`=32.
- Select walk:
  - Stimulus: during a full load, sample `select` before each transfer.
  - Required: values 32'h1, 32'h2, 32'h4, 32'h8, 32'h10, … 32'h80000000, exactly one bit set each cycle.
- Short load and stalls:
  - Stimulus: `len`=5, bits 1,0,1,1,1 with `bit_valid` dropped for 3 cycles after the 2nd bit.
  - Required: `pulse`=32'h0000001D. `select` and `count` frozen during the gap. `done` 1 cycle after the 5th bit.
- Ignored start:
  - Stimulus: assert `start` mid-LOAD and during DONE.
  - Required: no restart, `count` unaffected, final `pulse` identical to an undisturbed run.
- Reset mid-load:
  - Stimulus: drop `rst_n` for 1 cycle after 10 bits.
  - Required: next cycle `pulse`=0, `select`=0, `busy`=0, `bit_ready`=0, `done`=0. A fresh load then completes normally.
- Over-length `len`:
  - Stimulus: `len`=40 with an all-ones stream.
  - Required: 32 bits accepted, `pulse`=32'hFFFFFFFF, `count`=32.
